// File: rtl/bpb_update_ctrl_if.sv
// Write port of the 2-bit branch prediction buffer.
// master drives the port, slave is the buffer.
interface bpb_update_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             bpb_we;
  logic [IDX_W-1:0] bpb_waddr;
  logic [1:0]       bpb_wdata;

  modport master (
    output bpb_we,
    output bpb_waddr,
    output bpb_wdata
  );

  modport slave (
    input bpb_we,
    input bpb_waddr,
    input bpb_wdata
  );
endinterface

// File: rtl/bpb_update_ctrl.sv
// BPB write-side controller: counter update, mispredict, clear sweep.
// Optional statistics counters enabled by defining BPB_STATS_EN.
module bpb_update_ctrl #(
  parameter int         IDX_W      = 4,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         STAT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_branch,
  input  logic [IDX_W-1:0]  id_index,
  input  logic [1:0]        id_pred_state,
  input  logic              id_taken,
  input  logic              clear_req,
  bpb_update_ctrl_if.master wr,
  output logic              mispredict,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST = '1;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic             done_n;
  logic [1:0]       ns;
  logic             wrong;
  logic             hit;

  assign wrong = id_branch & (id_pred_state[1] != id_taken);
  assign hit   = id_branch & (id_index < ptr);

  // Saturating 2-bit counter step toward the resolved outcome
  always_comb begin
    ns = id_pred_state;
    if (id_taken) begin
      if (id_pred_state != 2'b11)
        ns = id_pred_state + 2'd1;
    end else if (id_pred_state != 2'b00) begin
      ns = id_pred_state - 2'd1;
    end
  end

  // State, sweep pointer and registered pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      ptr        <= '0;
      mispredict <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      mispredict <= wrong;
      clear_done <= done_n;
    end
  end

  // Next state and write-port arbitration
  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    done_n       = 1'b0;
    clear_busy   = 1'b0;
    wr.bpb_we    = 1'b0;
    wr.bpb_waddr = '0;
    wr.bpb_wdata = 2'b00;
    unique case (state)
      IDLE: begin
        wr.bpb_we = id_branch;
        if (id_branch) begin
          wr.bpb_waddr = id_index;
          wr.bpb_wdata = ns;
        end
        if (clear_req) begin
          state_n = SWEEP;
          ptr_n   = '0;
        end
      end
      SWEEP: begin
        clear_busy = 1'b1;
        wr.bpb_we  = 1'b1;
        if (hit) begin
          wr.bpb_waddr = id_index;
          wr.bpb_wdata = ns;
        end else begin
          wr.bpb_waddr = ptr;
          wr.bpb_wdata = INIT_STATE;
          ptr_n        = ptr + IDX_W'(1);
          if (ptr == LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
    endcase
  end

`ifdef BPB_STATS_EN
  logic [STAT_W-1:0] nb_q, nm_q;

  // Saturating branch / mispredict counters, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      nb_q <= '0;
      nm_q <= '0;
    end else begin
      if (id_branch && nb_q != '1)
        nb_q <= nb_q + STAT_W'(1);
      if (wrong && nm_q != '1)
        nm_q <= nm_q + STAT_W'(1);
    end
  end

  assign stat_branches = nb_q;
  assign stat_mispred  = nm_q;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: doc/bpb_update_ctrl.md
Name: bpb_update_ctrl

Overview:
Write-side controller for the 16-entry, 2-bit branch prediction buffer. It takes the branch outcome resolved in ID and computes the next saturating-counter state. It detects mispredicts and drives the buffer's single write port. It also runs a clear sequence that rewrites every entry to the init state, sharing the write port with normal updates. It sits between the ID-stage branch logic and the buffer's write port (write enable, write index, next state).

Parameters:
IDX_W, 4, index width; entries = 2**IDX_W
INIT_STATE, 2'b01, value written by the clear sequence (weakly not taken)
STAT_W, 16, width of statistics counters (optional feature only)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
id_branch  in  1  ID stage holds a conditional branch this cycle
id_index  in  IDX_W  buffer index of that branch (read in IF, piped to ID)
id_pred_state  in  2  counter state read in IF for that branch, piped to ID
id_taken  in  1  resolved outcome: 1 = taken
clear_req  in  1  one-cycle request to reinitialise the whole buffer
bpb_we  out  1  buffer write enable
bpb_waddr  out  IDX_W  buffer write index
bpb_wdata  out  2  buffer write data
mispredict  out  1  registered; one-cycle pulse, cycle after a wrong prediction
clear_busy  out  1  high while the clear sequence is running
clear_done  out  1  one-cycle pulse after the last entry is written
stat_branches  out  STAT_W  branches seen (optional feature)
stat_mispred  out  STAT_W  mispredicts seen (optional feature)

Behaviour:
- Reset (RST=1 at a CLK edge):
  - FSM goes to IDLE; sweep pointer = 0.
  - mispredict, clear_busy, clear_done = 0; stat counters = 0.
  - Reset mid-sweep aborts the sweep; no clear_done is produced.
- Next-state arithmetic, 2-bit saturating (00 SNT, 01 WNT, 10 WT, 11 ST):
  - taken: ns = (s==3) ? 3 : s+1
  - not taken: ns = (s==0) ? 0 : s-1
  - Prediction is id_pred_state[1].
- Mispredict:
  - mispredict <= id_branch & (id_pred_state[1] != id_taken).
  - Evaluated in every FSM state, including during a sweep.
- Write port outputs are combinational from the current-cycle inputs and state. The buffer captures them on the same CLK edge, so an update's latency is 0 cycles.
- FSM IDLE:
  - bpb_we = id_branch, bpb_waddr = id_index, bpb_wdata = ns.
  - clear_req=1 -> SWEEP with pointer 0. An id_branch update in the same cycle is still written.
- FSM SWEEP:
  - clear_busy = 1.
  - Default each cycle: write INIT_STATE to the pointer entry, then pointer += 1.
  - id_branch with id_index < pointer (entry already cleared): the update wins the port and writes ns. The sweep stalls this cycle; pointer holds.
  - id_branch with id_index >= pointer: the update is dropped (that entry will be reinitialised). The sweep write proceeds.
  - After writing the entry at pointer = 2**IDX_W-1: next cycle is IDLE with clear_done = 1 for one cycle. Pointer wraps to 0.
  - clear_req during SWEEP is ignored (no restart).
  - Minimum sweep length 16 cycles; each winning update adds 1 cycle.
- No X on outputs in any state. bpb_waddr and bpb_wdata are 0 when bpb_we=0.

Optional Feature:
BPB_STATS_EN:
- Defined:
  - stat_branches += 1 on every id_branch.
  - stat_mispred += 1 on every mispredict detection, including dropped updates.
  - Both saturate at all-ones and are cleared by RST only (not by the clear sequence).
- Undefined: both outputs are constant 0 and no counter flops exist.

Test Plan:
- Reset, then id_branch=1, idx=5, pred=01, taken=1 -> same cycle bpb_we=1, waddr=5, wdata=10; next cycle mispredict=1.
- Saturation: pred=11, taken=1 -> wdata=11, mispredict=0. Then pred=00, taken=0 -> wdata=00, mispredict=0.
- clear_req with no branches -> clear_busy for 16 cycles; writes idx 0..15 with data 01; clear_done pulses on cycle 17; FSM back in IDLE.
- During a sweep at pointer=8: branch idx=3, pred=10, taken=0 -> write idx 3 data 01, pointer holds 8, sweep ends one cycle later. Branch idx=12 -> dropped; entry 12 still written 01; mispredict still pulses if wrong.
- RST asserted at pointer=6 -> clear_busy=0 next cycle, no clear_done. A following branch update is written normally.
- With BPB_STATS_EN: 3 branches, 2 wrong -> stat_branches=3, stat_mispred=2. A clear sequence does not change them. Without the macro both read 0.
